// File: rtl/fano_pkg.sv
// Shared types and helpers for the Fano decoder sync-search controller.
package fano_pkg;

  localparam int unsigned N_CODE_RATES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST    = 2'd1,
    DWELL  = 2'd2,
    LOCKED = 2'd3
  } search_state_t;

  // Lowest set bit of mask; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set_bit(input logic [N_CODE_RATES-1:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = N_CODE_RATES - 1; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [1:0] next_set_bit(input logic [N_CODE_RATES-1:0] mask,
                                              input logic [1:0]              cur);
    logic [1:0] r;
    r = lowest_set_bit(mask);
    for (int i = N_CODE_RATES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fano_sync_search.sv
// Per-channel acquisition controller: steps a fano_decoder through
// (code_rate, llr_order) hypotheses until it reports sync, then holds.
// Optional macro FANO_SEARCH_STICKY_EN: on loss of lock, retry the same
// hypothesis instead of restarting the search from the first one.
module fano_sync_search
  import fano_pkg::*;
#(
  parameter int unsigned DWELL_WIDTH = 24,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [3:0]             i_rate_mask,
  input  logic [2:0]             i_order_max,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic [DWELL_WIDTH-1:0] i_loss_syms,
  input  logic                   i_vld,
  input  logic                   i_is_sync,
  output logic                   o_dec_reset,
  output logic [1:0]             o_code_rate,
  output logic [2:0]             o_llr_order,
  output logic                   o_locked,
  output logic [1:0]             o_state,
  output logic [CNT_WIDTH-1:0]   o_search_cnt
);

  localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  search_state_t            state;
  logic [RST_CNT_W-1:0]     rst_cnt;
  logic [DWELL_WIDTH-1:0]   dwell_cnt;
  logic [DWELL_WIDTH-1:0]   loss_cnt;

  logic [N_CODE_RATES-1:0]  eff_mask;
  logic [1:0]               first_rate;
  logic [1:0]               adv_rate;
  logic [2:0]               adv_order;
  logic [DWELL_WIDTH-1:0]   dwell_eff;
  logic [DWELL_WIDTH-1:0]   loss_eff;
  logic [DWELL_WIDTH:0]     dwell_inc;
  logic [DWELL_WIDTH:0]     loss_inc;
  logic                     dwell_done;
  logic                     loss_hit;
  logic [CNT_WIDTH-1:0]     cnt_inc;

  assign o_state = state;

  // Next hypothesis: order is the inner loop, rate steps through the mask with wrap.
  always_comb begin
    eff_mask   = (i_rate_mask == '0) ? N_CODE_RATES'(1) : i_rate_mask;
    first_rate = lowest_set_bit(eff_mask);
    adv_rate   = o_code_rate;
    adv_order  = o_llr_order;
    if (eff_mask[o_code_rate] && (o_llr_order < i_order_max)) begin
      adv_order = o_llr_order + 3'd1;
    end else begin
      adv_order = 3'd0;
      adv_rate  = next_set_bit(eff_mask, o_code_rate);
    end
  end

  // Dwell/loss terminal counts (zero thresholds act as one) and saturating attempt count.
  always_comb begin
    dwell_eff  = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
    loss_eff   = (i_loss_syms == '0) ? DWELL_WIDTH'(1) : i_loss_syms;
    dwell_inc  = {1'b0, dwell_cnt} + (DWELL_WIDTH+1)'(1);
    loss_inc   = {1'b0, loss_cnt} + (DWELL_WIDTH+1)'(1);
    dwell_done = i_vld && (dwell_inc >= {1'b0, dwell_eff});
    loss_hit   = i_vld && !i_is_sync && (loss_inc >= {1'b0, loss_eff});
    cnt_inc    = (o_search_cnt == '1) ? o_search_cnt : o_search_cnt + CNT_WIDTH'(1);
  end

  // Search FSM with registered outputs; enable fall pre-empts every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      o_dec_reset  <= 1'b0;
      o_code_rate  <= lowest_set_bit(i_rate_mask);
      o_llr_order  <= 3'd0;
      o_locked     <= 1'b0;
      o_search_cnt <= '0;
      rst_cnt      <= '0;
      dwell_cnt    <= '0;
      loss_cnt     <= '0;
    end else if (!i_enable) begin
      state       <= IDLE;
      o_dec_reset <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state        <= RST;
          o_dec_reset  <= 1'b1;
          rst_cnt      <= '0;
          o_search_cnt <= '0;
          o_code_rate  <= first_rate;
          o_llr_order  <= 3'd0;
        end
        RST: begin
          if (rst_cnt == RST_CNT_W'(RST_CYCLES - 1)) begin
            state       <= DWELL;
            o_dec_reset <= 1'b0;
            dwell_cnt   <= '0;
          end else begin
            rst_cnt <= rst_cnt + RST_CNT_W'(1);
          end
        end
        DWELL: begin
          if (dwell_done) begin
            if (i_is_sync) begin
              state    <= LOCKED;
              o_locked <= 1'b1;
              loss_cnt <= '0;
            end else begin
              state        <= RST;
              o_dec_reset  <= 1'b1;
              rst_cnt      <= '0;
              o_code_rate  <= adv_rate;
              o_llr_order  <= adv_order;
              o_search_cnt <= cnt_inc;
            end
          end else if (i_vld) begin
            dwell_cnt <= dwell_inc[DWELL_WIDTH-1:0];
          end
        end
        LOCKED: begin
          if (loss_hit) begin
            state       <= RST;
            o_locked    <= 1'b0;
            o_dec_reset <= 1'b1;
            rst_cnt     <= '0;
`ifndef FANO_SEARCH_STICKY_EN
            o_code_rate  <= first_rate;
            o_llr_order  <= 3'd0;
            o_search_cnt <= '0;
`endif
          end else if (i_vld) begin
            loss_cnt <= i_is_sync ? '0 : loss_inc[DWELL_WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fano_sync_search.md
Name: fano_sync_search

Overview:
- Per-channel acquisition controller for one fano_decoder instance; one copy per channel.
- While auto-search is enabled, it steps the decoder through (code_rate, llr_order) hypotheses.
- For each hypothesis it pulses the decoder reset, waits a dwell of valid symbols, then samples o_is_sync.
- On lock it holds the hypothesis, and re-searches on sustained loss.
- fano_decoder_axi muxes its outputs over the register values when search is enabled.

Parameters:
- DWELL_WIDTH, 24, width of dwell and loss counters (matches SYNC_PERIOD_WIDTH).
- RST_CYCLES, 4, cycles o_dec_reset is held high per hypothesis (>=1).
- CNT_WIDTH, 16, width of hypothesis-attempt counter.

Ports:
- clk  in  1  decoder clock; all logic is on this single clock.
- reset  in  1  synchronous, active-high reset.
- i_enable  in  1  search enable; level.
- i_rate_mask  in  4  bit k set = code_rate k is a candidate.
- i_order_max  in  3  highest llr_order tried (0..7).
- i_dwell  in  DWELL_WIDTH  valid symbols to wait before the sync check; 0 is treated as 1.
- i_loss_syms  in  DWELL_WIDTH  consecutive valid symbols with i_is_sync=0 that declare loss; 0 is treated as 1.
- i_vld  in  1  decoder input symbol valid.
- i_is_sync  in  1  fano_decoder o_is_sync.
- o_dec_reset  out  1  active-high decoder reset request.
- o_code_rate  out  2  current hypothesis rate.
- o_llr_order  out  3  current hypothesis order.
- o_locked  out  1  high in LOCKED.
- o_state  out  2  encoding: IDLE=0, RST=1, DWELL=2, LOCKED=3.
- o_search_cnt  out  CNT_WIDTH  hypotheses advanced since search start; saturating.

Behaviour:
- Reset values: state IDLE; o_dec_reset=0; o_code_rate = lowest set bit of i_rate_mask (0 if mask=0); o_llr_order=0; o_locked=0; o_search_cnt=0; all counters 0.
- Effective mask: i_rate_mask, or 4'b0001 when the mask is 0.
- IDLE:
  - o_dec_reset=0; hypothesis outputs hold.
  - i_enable=1 -> next cycle RST, o_search_cnt cleared, hypothesis loaded to (lowest set rate, order 0).
- RST:
  - o_dec_reset=1 for exactly RST_CYCLES cycles (registered output, no combinational path).
  - Then -> DWELL with the dwell counter at 0.
- DWELL:
  - The counter increments on each i_vld.
  - When the counter reaches max(i_dwell,1), i_is_sync is sampled in that same cycle.
  - Sampled 1 -> LOCKED next cycle.
  - Sampled 0 -> advance the hypothesis, o_search_cnt += 1 (saturating at all-ones), then -> RST.
- Advance order:
  - llr_order is the inner loop: it increments while < i_order_max.
  - Otherwise llr_order goes to 0 and code_rate goes to the next higher set bit of the effective mask.
  - Past the highest set bit it wraps to the lowest set bit (an endless pass).
  - Config is sampled at advance time. If the current llr_order > i_order_max (config shrank), the advance behaves as the llr_order-wrap case.
  - If the current rate is not in the mask, the advance moves to the next higher set bit, with wrap.
- LOCKED:
  - o_locked=1. A loss counter increments on i_vld with i_is_sync=0 and clears on any i_vld with i_is_sync=1.
  - Counter reaching max(i_loss_syms,1) -> loss event: o_locked falls next cycle, then recovery (see Optional Feature).
- i_enable=0 in any state:
  - Next cycle IDLE, o_dec_reset=0, o_locked=0.
  - Hypothesis and o_search_cnt hold (readable post-mortem).
- Simultaneous events:
  - The i_enable fall takes priority over any same-cycle transition.
  - reset takes priority over everything.
  - A dwell end and i_vld on the same cycle count as the terminal count (no extra symbol).
- Latency: i_enable rise -> o_dec_reset high 1 cycle later. Dwell end -> o_dec_reset high 1 cycle later on a miss, or o_locked high 1 cycle later on a hit.

Optional Feature:
- Macro: FANO_SEARCH_STICKY_EN.
- Defined: on loss of lock, go to RST with the same hypothesis (retry); o_search_cnt is not incremented. A subsequent failed dwell advances normally.
- Undefined: on loss of lock, go to RST with the hypothesis restarted at (lowest set rate, order 0); o_search_cnt is cleared.

Decomposition:
- fano_pkg contains:
  - typedef enum logic [1:0] search_state_t {IDLE, RST, DWELL, LOCKED};
  - function next_set_bit(mask, cur), returning the next higher set bit with wrap;
  - function lowest_set_bit(mask);
  - constant N_CODE_RATES=4.
- No sub-module needed; the advance logic is a single always_comb using the package functions.

Test Plan:
- mask=4'b0001, order_max=0, dwell=10, i_is_sync tied 1, i_vld every cycle -> o_dec_reset high for cycles 1-4 after enable; o_locked high 1 cycle after the 10th i_vld; o_search_cnt=0.
- mask=4'b1010, order_max=2, i_is_sync=0 -> hypotheses visited (1,0),(1,1),(1,2),(3,0),(3,1),(3,2),(1,0); o_search_cnt=6 at the second (1,0).
- Locked at (3,1), loss_syms=5: 4 unsynced i_vld then 1 synced, then 5 unsynced -> no loss after the first run; o_locked falls after the 5th unsynced symbol of the second run. Next hypothesis is (3,1) with STICKY, (1,0) without.
- mask=0, dwell=0 -> rate stays 0; each dwell ends on the first i_vld.
- Drop i_enable mid-DWELL -> IDLE next cycle, o_dec_reset=0, hypothesis held. Reassert -> restart at (lowest rate, 0) with o_search_cnt=0.
- Assert reset mid-RST -> all outputs at reset values next cycle; o_search_cnt force-loaded near all-ones saturates at 16'hFFFF.
